// File: rtl/lutram_arb_pkg.sv
// rtl/lutram_arb_pkg.sv - shared constants and state type for the LUTRAM arbiter
package lutram_arb_pkg;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;
endpackage

// File: rtl/lutram_arbiter_if.sv
// rtl/lutram_arbiter_if.sv - two requester ports of the LUTRAM arbiter
interface lutram_arbiter_if
    import lutram_arb_pkg::*;
#(
    parameter int DATA_W = 1
) ();
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] adr0;
    logic [DATA_W-1:0] din0;
    logic              gnt0;
    logic              rvld0;
    logic [DATA_W-1:0] dout0;

    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] adr1;
    logic [DATA_W-1:0] din1;
    logic              gnt1;
    logic              rvld1;
    logic [DATA_W-1:0] dout1;

    modport master (
        output req0, wr0, adr0, din0, req1, wr1, adr1, din1,
        input  gnt0, rvld0, dout0, gnt1, rvld1, dout1
    );

    modport slave (
        input  req0, wr0, adr0, din0, req1, wr1, adr1, din1,
        output gnt0, rvld0, dout0, gnt1, rvld1, dout1
    );
endinterface

// File: rtl/lutram_arb_rr.sv
// rtl/lutram_arb_rr.sv - two-way round-robin grant with last-grant register
module lutram_arb_rr (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);
    // 1 = port 1 was granted last, so port 0 wins the first contention
    logic r_last;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_en) begin
            if (i_req0 && (!i_req1 || r_last)) begin
                o_gnt0 = 1'b1;
            end else if (i_req1) begin
                o_gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (o_gnt0) begin
            r_last <= 1'b0;
        end else if (o_gnt1) begin
            r_last <= 1'b1;
        end
    end
endmodule

// File: rtl/lutram_arbiter.sv
// rtl/lutram_arbiter.sv - two-port arbiter for a 32-deep single-port LUTRAM
// Optional power-up/restart clear sequencer enabled by LUTRAM_ARB_CLEAR_EN.
module lutram_arbiter
    import lutram_arb_pkg::*;
#(
    parameter int                DATA_W    = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    lutram_arbiter_if.slave   s_port,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_a,
    output logic [DATA_W-1:0] o_ram_d,
    input  logic [DATA_W-1:0] i_ram_o,
    output logic              o_busy
);
    logic              w_serve;
    logic              w_clearing;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              r_rvld0;
    logic              r_rvld1;
    logic [DATA_W-1:0] r_dout0;
    logic [DATA_W-1:0] r_dout1;

`ifdef LUTRAM_ARB_CLEAR_EN
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        if (i_clr) begin
            w_state_nxt    = CLEAR;
            w_clr_addr_nxt = '0;
        end else if (r_state == CLEAR) begin
            if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
                w_state_nxt    = SERVE;
                w_clr_addr_nxt = '0;
            end else begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
            end
        end
    end

    // Gated by reset so the RAM and grants go quiet the moment reset asserts
    assign w_serve    = i_rst_n && (r_state == SERVE);
    assign w_clearing = i_rst_n && (r_state == CLEAR);
    assign w_clr_addr = r_clr_addr;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_clr;
    assign w_serve      = i_rst_n;
    assign w_clearing   = 1'b0;
    assign w_clr_addr   = '0;
`endif

    lutram_arb_rr u_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_serve),
        .i_req0  (s_port.req0),
        .i_req1  (s_port.req1),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    always_comb begin
        o_ram_we = 1'b0;
        o_ram_a  = '0;
        o_ram_d  = '0;
        if (w_clearing) begin
            o_ram_we = 1'b1;
            o_ram_a  = w_clr_addr;
            o_ram_d  = CLEAR_VAL;
        end else if (w_gnt0) begin
            o_ram_we = s_port.wr0;
            o_ram_a  = s_port.adr0;
            o_ram_d  = s_port.din0;
        end else if (w_gnt1) begin
            o_ram_we = s_port.wr1;
            o_ram_a  = s_port.adr1;
            o_ram_d  = s_port.din1;
        end
    end

    // Read data is taken from the asynchronous RAM output at the grant edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvld0 <= 1'b0;
            r_rvld1 <= 1'b0;
            r_dout0 <= '0;
            r_dout1 <= '0;
        end else begin
            r_rvld0 <= w_gnt0 && !s_port.wr0;
            r_rvld1 <= w_gnt1 && !s_port.wr1;
            if (w_gnt0 && !s_port.wr0) begin
                r_dout0 <= i_ram_o;
            end
            if (w_gnt1 && !s_port.wr1) begin
                r_dout1 <= i_ram_o;
            end
        end
    end

    assign s_port.gnt0  = w_gnt0;
    assign s_port.gnt1  = w_gnt1;
    assign s_port.rvld0 = r_rvld0;
    assign s_port.rvld1 = r_rvld1;
    assign s_port.dout0 = r_dout0;
    assign s_port.dout1 = r_dout1;
    assign o_busy       = w_clearing;
endmodule

// File: tb/tb_lutram_arbiter.sv
// tb/tb_lutram_arbiter.sv - directed self-checking bench for lutram_arbiter
module tb_lutram_arbiter;
    localparam int             DW = 4;
    localparam logic [DW-1:0]  CV = 4'hA;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr   = 1'b0;
    logic          ram_we;
    logic [4:0]    ram_a;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_o;
    logic          busy;
    logic [DW-1:0] mem [32];
    int            errors = 0;
    int            checks = 0;

    lutram_arbiter_if #(.DATA_W(DW)) pif ();

    lutram_arbiter #(.DATA_W(DW), .CLEAR_VAL(CV)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clr    (clr),
        .s_port   (pif),
        .o_ram_we (ram_we),
        .o_ram_a  (ram_a),
        .o_ram_d  (ram_d),
        .i_ram_o  (ram_o),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;
    assign ram_o = mem[ram_a];

    task automatic idle();
        pif.req0 = 0; pif.wr0 = 0; pif.adr0 = 0; pif.din0 = 0;
        pif.req1 = 0; pif.wr1 = 0; pif.adr1 = 0; pif.din1 = 0;
    endtask

    task automatic do_reset();
        idle(); clr = 0; rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
`ifdef LUTRAM_ARB_CLEAR_EN
        repeat (32) @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) mem[i] = DW'(i);
        idle(); pif.req0 = 1; pif.req1 = 1; pif.wr0 = 1; pif.adr0 = 5'd9; pif.din0 = 4'h3;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pif.gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0: got %b exp 0", pif.gnt0); end
        checks++; if (pif.gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1: got %b exp 0", pif.gnt1); end
        checks++; if ({pif.rvld0, pif.rvld1} !== 2'b00) begin errors++; $display("FAIL rst_rvld: got %b exp 00", {pif.rvld0, pif.rvld1}); end
        checks++; if ({pif.dout0, pif.dout1} !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h exp 00", {pif.dout0, pif.dout1}); end
        checks++; if ({ram_we, ram_a, ram_d} !== 10'd0) begin errors++; $display("FAIL rst_ram: got we=%b a=%0d d=%h exp 0", ram_we, ram_a, ram_d); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    endtask

`ifdef LUTRAM_ARB_CLEAR_EN
    task automatic test_clear_seq();
        idle(); pif.req0 = 1; pif.adr0 = 5'd4;
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++; if (busy !== 1'b1 || ram_we !== 1'b1 || ram_a !== 5'(i) || ram_d !== CV || pif.gnt0 !== 1'b0)
                begin errors++; $display("FAIL clear_step%0d: busy=%b we=%b a=%0d d=%h gnt0=%b exp 1 1 %0d %h 0", i, busy, ram_we, ram_a, ram_d, pif.gnt0, i, CV); end
            @(posedge clk);
            #1;
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy: got %b exp 0", busy); end
        checks++; if (pif.gnt0 !== 1'b1) begin errors++; $display("FAIL clear_done_gnt0: got %b exp 1", pif.gnt0); end
        checks++; if (mem[31] !== CV) begin errors++; $display("FAIL clear_mem31: got %h exp %h", mem[31], CV); end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        idle(); rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (17) @(posedge clk);
        #2;
        checks++; if (ram_a !== 5'd17 || busy !== 1'b1) begin errors++; $display("FAIL midclr_addr: got a=%0d busy=%b exp 17 1", ram_a, busy); end
        rst_n = 0;
        #1;
        checks++; if ({ram_we, ram_a, ram_d, busy} !== 11'd0) begin errors++; $display("FAIL midclr_rst_out: got we=%b a=%0d d=%h busy=%b exp 0", ram_we, ram_a, ram_d, busy); end
        @(posedge clk);
        #1 rst_n = 1;
        #1;
        checks++; if (ram_a !== 5'd0 || busy !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL midclr_restart: got a=%0d busy=%b we=%b exp 0 1 1", ram_a, busy, ram_we); end
        repeat (32) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclr_done: got busy=%b exp 0", busy); end
    endtask
`endif

    task automatic test_write_read();
        pif.req0 = 1; pif.wr0 = 1; pif.adr0 = 5'd5; pif.din0 = 4'h1;
        #1;
        checks++; if (pif.gnt0 !== 1'b1 || pif.gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt: got %b%b exp 10", pif.gnt0, pif.gnt1); end
        checks++; if (ram_we !== 1'b1 || ram_a !== 5'd5 || ram_d !== 4'h1) begin errors++; $display("FAIL wr_ram: got we=%b a=%0d d=%h exp 1 5 1", ram_we, ram_a, ram_d); end
        @(posedge clk);
        #1 pif.wr0 = 0;
        #1;
        checks++; if (pif.gnt0 !== 1'b1 || ram_we !== 1'b0 || ram_a !== 5'd5) begin errors++; $display("FAIL rd_gnt: got gnt0=%b we=%b a=%0d exp 1 0 5", pif.gnt0, ram_we, ram_a); end
        checks++; if (pif.rvld0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvld: got %b exp 0", pif.rvld0); end
        @(posedge clk);
        #1 idle();
        #1;
        checks++; if (pif.rvld0 !== 1'b1 || pif.dout0 !== 4'h1) begin errors++; $display("FAIL rd_data: got rvld0=%b dout0=%h exp 1 1", pif.rvld0, pif.dout0); end
        checks++; if (pif.rvld1 !== 1'b0) begin errors++; $display("FAIL rd_other_port: got rvld1=%b exp 0", pif.rvld1); end
        @(posedge clk);
        #1;
        checks++; if (pif.rvld0 !== 1'b0 || pif.dout0 !== 4'h1) begin errors++; $display("FAIL rd_hold: got rvld0=%b dout0=%h exp 0 1", pif.rvld0, pif.dout0); end
    endtask

    task automatic test_back_to_back();
        pif.req1 = 1; pif.wr1 = 1; pif.adr1 = 5'd3; pif.din1 = 4'h6;
        #1;
        checks++; if (pif.gnt1 !== 1'b1 || ram_a !== 5'd3 || ram_d !== 4'h6) begin errors++; $display("FAIL b2b_first: got gnt1=%b a=%0d d=%h exp 1 3 6", pif.gnt1, ram_a, ram_d); end
        @(posedge clk);
        #1 pif.adr1 = 5'd7; pif.din1 = 4'h9;
        #1;
        checks++; if (pif.gnt1 !== 1'b1 || ram_we !== 1'b1 || ram_a !== 5'd7 || ram_d !== 4'h9) begin errors++; $display("FAIL b2b_second: got gnt1=%b we=%b a=%0d d=%h exp 1 1 7 9", pif.gnt1, ram_we, ram_a, ram_d); end
        @(posedge clk);
        #1 idle();
        checks++; if (mem[3] !== 4'h6 || mem[7] !== 4'h9) begin errors++; $display("FAIL b2b_mem: got %h %h exp 6 9", mem[3], mem[7]); end
    endtask

    task automatic test_contention();
        pif.req0 = 1; pif.adr0 = 5'd3;
        pif.req1 = 1; pif.adr1 = 5'd7;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (pif.gnt0 !== (c % 2 == 0) || pif.gnt1 !== (c % 2 == 1) || ram_a !== ((c % 2 == 0) ? 5'd3 : 5'd7) || ram_we !== 1'b0)
                begin errors++; $display("FAIL rr_cycle%0d: got gnt=%b%b a=%0d we=%b exp gnt0=%0d", c, pif.gnt0, pif.gnt1, ram_a, ram_we, (c % 2 == 0)); end
            @(posedge clk);
            #1;
            if (c % 2 == 0) begin
                checks++; if (pif.rvld0 !== 1'b1 || pif.rvld1 !== 1'b0 || pif.dout0 !== 4'h6) begin errors++; $display("FAIL rr_rd0_%0d: got rvld=%b%b dout0=%h exp 10 6", c, pif.rvld0, pif.rvld1, pif.dout0); end
            end else begin
                checks++; if (pif.rvld0 !== 1'b0 || pif.rvld1 !== 1'b1 || pif.dout1 !== 4'h9) begin errors++; $display("FAIL rr_rd1_%0d: got rvld=%b%b dout1=%h exp 01 9", c, pif.rvld0, pif.rvld1, pif.dout1); end
            end
        end
        idle();
    endtask

    task automatic test_clr();
        pif.req1 = 1; pif.adr1 = 5'd7; clr = 1;
        #1;
        checks++; if (pif.gnt1 !== 1'b1) begin errors++; $display("FAIL clr_cycle_gnt1: got %b exp 1", pif.gnt1); end
        @(posedge clk);
        #1 clr = 0;
        #1;
        checks++; if (pif.rvld1 !== 1'b1 || pif.dout1 !== 4'h9) begin errors++; $display("FAIL clr_rd_done: got rvld1=%b dout1=%h exp 1 9", pif.rvld1, pif.dout1); end
`ifdef LUTRAM_ARB_CLEAR_EN
        for (int i = 0; i < 32; i++) begin
            checks++; if (pif.gnt1 !== 1'b0 || busy !== 1'b1 || ram_a !== 5'(i) || ram_d !== CV)
                begin errors++; $display("FAIL clr_step%0d: gnt1=%b busy=%b a=%0d d=%h exp 0 1 %0d %h", i, pif.gnt1, busy, ram_a, ram_d, i, CV); end
            @(posedge clk);
            #2;
        end
        checks++; if (pif.gnt1 !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clr_resume: got gnt1=%b busy=%b exp 1 0", pif.gnt1, busy); end
        @(posedge clk);
        #1;
        checks++; if (pif.rvld1 !== 1'b1 || pif.dout1 !== CV) begin errors++; $display("FAIL clr_cleared_data: got rvld1=%b dout1=%h exp 1 %h", pif.rvld1, pif.dout1, CV); end
`else
        checks++; if (pif.gnt1 !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clr_ignored: got gnt1=%b busy=%b exp 1 0", pif.gnt1, busy); end
        @(posedge clk);
        #1;
        checks++; if (pif.rvld1 !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL clr_no_clear: got rvld1=%b we=%b exp 1 0", pif.rvld1, ram_we); end
`endif
        idle();
    endtask

    initial begin
        idle();
        test_reset();
`ifdef LUTRAM_ARB_CLEAR_EN
        test_clear_seq();
        test_reset_mid_clear();
`else
        do_reset();
`endif
        test_write_read();
        do_reset();
        test_back_to_back();
        test_contention();
        test_clr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
